// File: rtl/oam_dma_if.sv
// OAM DMA bus bundle: core-side snoop/halt signals and DMA bus-side signals.
// The master modport is the DMA engine; slave is the surrounding system.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_o;
  logic        cpu_rw;
  logic        cpu_ready;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_o;
  logic        bus_rw;
  logic [7:0]  bus_data_i;

  modport master (
    input  cpu_addr, cpu_data_o, cpu_rw, bus_data_i,
    output cpu_ready, dma_active, bus_addr, bus_data_o, bus_rw
  );

  modport slave (
    output cpu_addr, cpu_data_o, cpu_rw, bus_data_i,
    input  cpu_ready, dma_active, bus_addr, bus_data_o, bus_rw
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: snoops the trigger write, halts the core and copies
// one 256-byte page to the OAM data port as read/write pairs.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR     = 16'h2004
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        dma_active_q, dma_active_d;
  logic        bus_rw_q, bus_rw_d;
  logic [15:0] bus_addr_q, bus_addr_d;

  always_comb begin
    state_d = state_q;
    phase_d = ~phase_q;
    page_d  = page_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_addr == TRIGGER_ADDR && !bus.cpu_rw) begin
          page_d  = bus.cpu_data_o;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      // Reads must land on phase 0, so insert ALIGN when needed
      S_HALT:  state_d = phase_d ? S_ALIGN : S_READ;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        byte_d  = bus.bus_data_i;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    cpu_ready_d  = (state_d == S_IDLE);
    dma_active_d = (state_d == S_READ) || (state_d == S_WRITE);
    bus_rw_d     = (state_d != S_WRITE);
    bus_addr_d   = bus_addr_q;
    if (state_d == S_READ) begin
      bus_addr_d = {page_d, idx_d};
    end else if (state_d == S_WRITE) begin
      bus_addr_d = OAM_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      byte_q       <= 8'h00;
      cpu_ready_q  <= 1'b1;
      dma_active_q <= 1'b0;
      bus_rw_q     <= 1'b1;
      bus_addr_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      cpu_ready_q  <= cpu_ready_d;
      dma_active_q <= dma_active_d;
      bus_rw_q     <= bus_rw_d;
      bus_addr_q   <= bus_addr_d;
    end
  end

  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.dma_active = dma_active_q;
  assign bus.bus_rw     = bus_rw_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_data_o = byte_q;

endmodule
